// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: writeback, two read ports and the issue-side scoreboard.
// The master side drives indices, strobes and data; the slave side returns read data and busy status.
interface reg_file_sb_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int CNT_W      = 4
);
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] din;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic [DATA_WIDTH-1:0] r1;
    logic [DATA_WIDTH-1:0] r2;
    logic                  busy1;
    logic                  busy2;
    logic                  alloc_en;
    logic [ADDR_WIDTH-1:0] alloc_rd;
    logic                  alloc_stall;
    logic [CNT_W-1:0]      busy_cnt;

    modport master (
        output wr_en, rd, din, rs1, rs2, alloc_en, alloc_rd,
        input  r1, r2, busy1, busy2, alloc_stall, busy_cnt
    );

    modport slave (
        input  wr_en, rd, din, rs1, rs2, alloc_en, alloc_rd,
        output r1, r2, busy1, busy2, alloc_stall, busy_cnt
    );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one write port and a per-register
// busy scoreboard so the issue stage can see RAW/WAW hazards directly.
module reg_file_sb #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_REGS   = 8,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_file_sb_if.slave  bus
);
    localparam int CNT_W = $clog2(NUM_REGS + 1);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;
    logic [CNT_W-1:0]      busy_cnt_q;
    logic [CNT_W-1:0]      busy_cnt_d;

    logic [DATA_WIDTH-1:0] r1_raw, r2_raw;
    logic                  b1_raw, b2_raw, b_alloc, b_wr;
    logic                  v1, v2, v_alloc, v_wr;
    logic                  fwd1, fwd2, stall, alloc_ok, cnt_inc, cnt_dec;

    function automatic logic idx_valid(input logic [ADDR_WIDTH-1:0] idx);
        return (32'(idx) < NUM_REGS) && !((ZERO_REG != 0) && (idx == '0));
    endfunction

    always_comb begin
        r1_raw  = '0;
        r2_raw  = '0;
        b1_raw  = 1'b0;
        b2_raw  = 1'b0;
        b_alloc = 1'b0;
        b_wr    = 1'b0;
        // Loop-based muxes keep out-of-range indices from touching the array.
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.rs1 == ADDR_WIDTH'(i)) begin
                r1_raw = regs_q[i];
                b1_raw = busy_q[i];
            end
            if (bus.rs2 == ADDR_WIDTH'(i)) begin
                r2_raw = regs_q[i];
                b2_raw = busy_q[i];
            end
            if (bus.alloc_rd == ADDR_WIDTH'(i)) b_alloc = busy_q[i];
            if (bus.rd == ADDR_WIDTH'(i))       b_wr    = busy_q[i];
        end

        v1      = idx_valid(bus.rs1);
        v2      = idx_valid(bus.rs2);
        v_alloc = idx_valid(bus.alloc_rd);
        v_wr    = idx_valid(bus.rd);
        fwd1    = (BYPASS != 0) && bus.wr_en && (bus.rd == bus.rs1);
        fwd2    = (BYPASS != 0) && bus.wr_en && (bus.rd == bus.rs2);

        // A same-cycle writeback to the target retires the old producer, so no WAW stall.
        stall    = bus.alloc_en && v_alloc && b_alloc && !(bus.wr_en && (bus.rd == bus.alloc_rd));
        alloc_ok = bus.alloc_en && v_alloc && !stall;

        regs_d = regs_q;
        busy_d = busy_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.wr_en && v_wr && (bus.rd == ADDR_WIDTH'(i))) regs_d[i] = bus.din;
            if (alloc_ok && (bus.alloc_rd == ADDR_WIDTH'(i)))    busy_d[i] = 1'b1;
            else if (bus.wr_en && (bus.rd == ADDR_WIDTH'(i)))    busy_d[i] = 1'b0;
        end

        cnt_inc    = alloc_ok && !b_alloc;
        cnt_dec    = bus.wr_en && v_wr && b_wr && !(alloc_ok && (bus.alloc_rd == bus.rd));
        busy_cnt_d = busy_cnt_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);

        bus.r1          = '0;
        bus.r2          = '0;
        bus.busy1       = 1'b0;
        bus.busy2       = 1'b0;
        bus.alloc_stall = 1'b0;
        bus.busy_cnt    = '0;
        if (rst_n) begin
            bus.r1          = !v1 ? '0 : (fwd1 ? bus.din : r1_raw);
            bus.r2          = !v2 ? '0 : (fwd2 ? bus.din : r2_raw);
            bus.busy1       = v1 && b1_raw && !fwd1;
            bus.busy2       = v2 && b2_raw && !fwd2;
            bus.alloc_stall = stall;
            bus.busy_cnt    = busy_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end
endmodule
